// File: rtl/fpa_issue_arbiter_if.sv
// Requester, response, adder and drain-control bundle for fpa_issue_arbiter.
// The gnt_cnt0/gnt_cnt1 members exist only when FPA_ARB_CNT_EN is defined.
interface fpa_issue_arbiter_if #(
    parameter int CW = 16
);
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic        rsp0_valid;
    logic [31:0] rsp0_data;
    logic        rsp1_valid;
    logic [31:0] rsp1_data;
    logic        fpa_in_valid;
    logic [31:0] fpa_a;
    logic [31:0] fpa_b;
    logic [31:0] fpa_result;
    logic        drain_req;
    logic        idle;

    if (CW < 1) begin : g_bad_cw
        $error("fpa_issue_arbiter_if: CW must be at least 1");
    end

`ifdef FPA_ARB_CNT_EN
    logic [CW-1:0] gnt_cnt0;
    logic [CW-1:0] gnt_cnt1;

    modport slave (
        input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
        output fpa_in_valid, fpa_a, fpa_b,
        input  fpa_result, drain_req,
        output idle, gnt_cnt0, gnt_cnt1
    );
    modport master (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
        input  fpa_in_valid, fpa_a, fpa_b,
        output fpa_result, drain_req,
        input  idle, gnt_cnt0, gnt_cnt1
    );
`else
    modport slave (
        input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
        output fpa_in_valid, fpa_a, fpa_b,
        input  fpa_result, drain_req,
        output idle
    );
    modport master (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
        input  fpa_in_valid, fpa_a, fpa_b,
        output fpa_result, drain_req,
        input  idle
    );
`endif
endinterface

// File: rtl/fpa_issue_arbiter.sv
// Round-robin two-port issue arbiter for a LAT-cycle pipelined FP adder, with owner tags,
// per-port credit limits and drain/halt. Define FPA_ARB_CNT_EN to add per-port grant counters.
module fpa_issue_arbiter #(
    parameter int LAT    = 3,
    parameter int MAXOUT = 4,
    parameter int CW     = 16
) (
    input logic                clk,
    input logic                rst_n,
    fpa_issue_arbiter_if.slave bus
);
    typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

    state_t         state;
    state_t         state_next;
    logic           last;
    logic [3:0]     out0;
    logic [3:0]     out1;
    logic           iss_valid;
    logic           iss_id;
    logic [LAT-1:0] tag_valid;
    logic [LAT-1:0] tag_id;
    logic           elig0;
    logic           elig1;
    logic           gnt0;
    logic           gnt1;
    logic           pipe_empty;

    if (LAT < 1) begin : g_bad_lat
        $error("fpa_issue_arbiter: LAT must be at least 1");
    end
    if (MAXOUT < 1 || MAXOUT > 15) begin : g_bad_maxout
        $error("fpa_issue_arbiter: MAXOUT must be in 1..15");
    end
    if (CW < 1) begin : g_bad_cw
        $error("fpa_issue_arbiter: CW must be at least 1");
    end

    // On a tie the port that did not win last time is granted.
    always_comb begin
        elig0 = rst_n && (state == RUN) && bus.req0_valid && (out0 < 4'(MAXOUT));
        elig1 = rst_n && (state == RUN) && bus.req1_valid && (out1 < 4'(MAXOUT));
        gnt0  = elig0 && (!elig1 || last);
        gnt1  = elig1 && (!elig0 || !last);
    end

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;
    assign bus.fpa_in_valid = iss_valid;
    assign pipe_empty = (out0 == 4'd0) && (out1 == 4'd0) && !iss_valid && (tag_valid == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            iss_valid <= 1'b0;
            iss_id    <= 1'b0;
            bus.fpa_a <= '0;
            bus.fpa_b <= '0;
            last      <= 1'b1;
        end else begin
            iss_valid <= gnt0 | gnt1;
            if (gnt0 | gnt1) begin
                iss_id    <= gnt1;
                bus.fpa_a <= gnt1 ? bus.req1_a : bus.req0_a;
                bus.fpa_b <= gnt1 ? bus.req1_b : bus.req0_b;
                last      <= gnt1;
            end
        end
    end

    // Tag line is fed from the issue register so its tail lines up with fpa_result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_valid <= '0;
            tag_id    <= '0;
        end else begin
            tag_valid[0] <= iss_valid;
            tag_id[0]    <= iss_id;
            for (int i = 1; i < LAT; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_id[i]    <= tag_id[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.rsp0_valid <= 1'b0;
            bus.rsp1_valid <= 1'b0;
            bus.rsp0_data  <= '0;
            bus.rsp1_data  <= '0;
        end else begin
            bus.rsp0_valid <= tag_valid[LAT-1] && !tag_id[LAT-1];
            bus.rsp1_valid <= tag_valid[LAT-1] && tag_id[LAT-1];
            if (tag_valid[LAT-1] && !tag_id[LAT-1]) begin
                bus.rsp0_data <= bus.fpa_result;
            end
            if (tag_valid[LAT-1] && tag_id[LAT-1]) begin
                bus.rsp1_data <= bus.fpa_result;
            end
        end
    end

    // A credit is returned in the cycle its response pulse is presented.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out0 <= 4'd0;
            out1 <= 4'd0;
        end else begin
            out0 <= out0 + {3'b000, gnt0} - {3'b000, bus.rsp0_valid};
            out1 <= out1 + {3'b000, gnt1} - {3'b000, bus.rsp1_valid};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        bus.idle   = 1'b0;
        case (state)
            RUN: begin
                if (bus.drain_req) state_next = DRAIN;
            end
            DRAIN: begin
                if (!bus.drain_req) state_next = RUN;
                else if (pipe_empty) state_next = HALT;
            end
            HALT: begin
                bus.idle = rst_n;
                if (!bus.drain_req) state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

`ifdef FPA_ARB_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.gnt_cnt0 <= '0;
            bus.gnt_cnt1 <= '0;
        end else begin
            if (gnt0) bus.gnt_cnt0 <= bus.gnt_cnt0 + CW'(1);
            if (gnt1) bus.gnt_cnt1 <= bus.gnt_cnt1 + CW'(1);
        end
    end
`endif
endmodule

// File: doc/fpa_issue_arbiter.md
# fpa_issue_arbiter

Two-requester arbiter and sequencer for the shared pipelined single-precision floating-point adder. Accepts operand pairs from two requesters over valid/ready handshakes and grants them round-robin. Issues one operation per cycle into the adder and tracks each in-flight operation's owner through a tag delay line matched to the adder latency. Routes each sum back to its owner, bounds outstanding operations per requester, and supports a drain/halt sequence for safe reconfiguration.

## Interface
Parameters:
- LAT, 3, adder latency in cycles from `fpa_in_valid` sample to `fpa_result` valid; legal range ≥1
- MAXOUT, 4, maximum outstanding operations per requester; legal range 1–15
- CW, 16, grant-counter width (used only with FPA_ARB_CNT_EN)

Ports (clock and reset first):
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- req0_valid / req1_valid  in  1  requester has an operand pair
- req0_a, req0_b / req1_a, req1_b  in  32  IEEE-754 single operands
- req0_ready / req1_ready  out  1  grant; handshake completes when valid & ready at the edge
- rsp0_valid / rsp1_valid  out  1  one-cycle result pulse; no back-pressure
- rsp0_data / rsp1_data  out  32  sum returned to that requester
- fpa_in_valid  out  1  issue strobe to adder
- fpa_a, fpa_b  out  32  operands to adder
- fpa_result  in  32  adder output, valid exactly LAT cycles after the issue cycle
- drain_req  in  1  stop granting and empty the pipeline
- idle  out  1  high in HALT state
- gnt_cnt0 / gnt_cnt1  out  CW  grant counters (FPA_ARB_CNT_EN only)

## Operation
- Eligibility: port k is eligible when reqk_valid=1, outk<MAXOUT, and state=RUN.
- Arbitration: combinational from registered priority bit `last`. Only one ready is high per cycle, and a ready is high only for an eligible port. With both ports eligible, the port ≠ `last` wins. A single eligible port always wins. `last` updates to the granted port on each handshake.
- Issue register: captures the granted operands. fpa_in_valid=1 in the following cycle; otherwise fpa_in_valid=0 and fpa_a/fpa_b hold their previous values.
- Tag line: LAT-deep shift register of {valid, id}, advancing every cycle. Its head enters with the issue register. At its tail, fpa_result is captured into rsp{id}_data, and rsp{id}_valid pulses for one cycle.
- Outstanding counters out0/out1: increment on handshake, decrement on rsp pulse. Simultaneous increment and decrement leaves the counter unchanged. A counter never exceeds MAXOUT and never underflows.
- FSM:
  - RUN → DRAIN when drain_req=1. Grants stop in the same cycle drain_req is sampled high, because ready is gated by state.
  - DRAIN → HALT when out0=out1=0, the issue register is empty, and the tag line is empty.
  - DRAIN → RUN if drain_req falls before the pipeline is empty.
  - HALT → RUN when drain_req=0.
- Operations already granted always complete and return, regardless of drain.

## Timing
- Handshake at edge T → fpa_in_valid high during cycle T+1 → fpa_result sampled at edge T+1+LAT → rspk_valid high during cycle T+2+LAT. Total latency: LAT+2.
- Throughput: one grant per cycle. With both ports continuously eligible, grants alternate 0,1,0,1…
- Results return in issue order. A port's results never reorder.
- Reset values (rst_n=0 sampled at an edge):
  - state=RUN, last=1 (port 0 wins first tie)
  - out0=out1=0; tag line, issue valid, and rsp valids cleared
  - fpa_in_valid=0, fpa_a=fpa_b=0, rsp data=0, idle=0, ready=0 during reset
- Reset mid-operation discards all in-flight tags. Adder results arriving after reset produce no response.

## Configuration
- FPA_ARB_CNT_EN defined:
  - gnt_cnt0/gnt_cnt1 ports exist.
  - Each counts handshakes on its port and wraps from 2^CW−1 to 0.
  - Both clear on reset.
- FPA_ARB_CNT_EN undefined: the ports and counters are absent; all other behaviour is identical.

## Test plan
- Single op: LAT=3, req0 a=0x3F800000 (1.0), b=0x40000000 (2.0) with an adder model → rsp0_valid exactly 5 cycles after the handshake, rsp0_data=0x40400000; rsp1_valid stays 0.
- Contention: both valid continuously from reset with distinct operands → grants 0,1,0,1,…; each port's responses carry its own sums in order; fpa_in_valid=1 every cycle.
- Credit limit: MAXOUT=4, req0 held valid, adder model returns results → exactly 4 grants. Ready drops until the first rsp0 pulse, then exactly one further grant.
- Drain: pulse traffic, then raise drain_req → no ready from the next cycle; idle rises after the last rsp pulse (out=0, tags empty). Lowering drain_req → RUN; the next grant goes to the port ≠ last.
- Reset mid-flight: 3 ops in flight, rst_n=0 for one edge → no rsp pulses afterward, out0=out1=0, the first post-reset tie grants port 0.
- FPA_ARB_CNT_EN with CW=4: 17 grants on port 0 → gnt_cnt0=1, gnt_cnt1 unchanged.
